// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: loads, stores and pass-through results for a 64-bit pipeline.
// Define MEM_TIMEOUT_EN to abandon requests that see no mem_ack within TIMEOUT_CYCLES cycles.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_data,
  input  logic [63:0] in_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_strb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        misalign,
  output logic        mem_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  state_e      state_q, state_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_strb_q, mem_strb_d;
  logic [2:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic        mem_err_q, mem_err_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, aligned, legal, accept, timeout;
  logic [7:0]  strb_base;
  logic [63:0] lane, load_val;

  assign opcode   = in_op[6:0];
  assign funct3   = in_op[9:7];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign legal    = is_load ? (funct3 != 3'd7) : !funct3[2];

  // funct3[1:0] encodes the access size for both loads and stores
  always_comb begin
    aligned   = 1'b1;
    strb_base = 8'h01;
    case (funct3[1:0])
      2'd0: begin aligned = 1'b1;                strb_base = 8'h01; end
      2'd1: begin aligned = !in_addr[0];         strb_base = 8'h03; end
      2'd2: begin aligned = (in_addr[1:0] == 2'd0); strb_base = 8'h0F; end
      default: begin aligned = (in_addr[2:0] == 3'd0); strb_base = 8'hFF; end
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    load_val = {{56{lane[7]}}, lane[7:0]};
      3'd1:    load_val = {{48{lane[15]}}, lane[15:0]};
      3'd2:    load_val = {{32{lane[31]}}, lane[31:0]};
      3'd4:    load_val = {56'd0, lane[7:0]};
      3'd5:    load_val = {48'd0, lane[15:0]};
      3'd6:    load_val = {32'd0, lane[31:0]};
      default: load_val = lane;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q is zero on the first REQ cycle; the last allowed cycle is TIMEOUT_CYCLES-1
  assign timeout = (state_q == REQ) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (!mem_ack)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_strb_d  = mem_strb_q;
    off_d       = off_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    wb_en_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    mem_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load || is_store) begin
            if (legal && aligned) begin
              state_d     = REQ;
              mem_we_d    = is_store;
              mem_addr_d  = {in_addr[63:3], 3'b000};
              mem_wdata_d = is_store ? (in_data << {in_addr[2:0], 3'b000}) : 64'd0;
              mem_strb_d  = is_store ? (strb_base << in_addr[2:0]) : 8'h00;
              off_d       = in_addr[2:0];
              f3_d        = funct3;
              rd_d        = in_rd;
            end else begin
              misalign_d = 1'b1;
            end
          end else if (in_rd != 5'd0) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = in_rd;
            wb_data_d = in_data;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (!mem_we_q && (rd_q != 5'd0)) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = load_val;
          end
        end else if (timeout) begin
          state_d   = IDLE;
          mem_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      mem_strb_q  <= 8'h00;
      off_q       <= 3'd0;
      f3_q        <= 3'd0;
      rd_q        <= 5'd0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 64'd0;
      misalign_q  <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_strb_q  <= mem_strb_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_strb  = mem_strb_q;
  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign misalign  = misalign_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a transaction-level reference model.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_wb_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_op;
  logic [4:0]  in_rd;
  logic [63:0] in_data, in_addr;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_strb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misalign, mem_err;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_data(in_data), .in_addr(in_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .mem_err(mem_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [4:0]  exp_rd;
  logic [63:0] exp_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_legal(input bit ld, input logic [2:0] f3, input logic [63:0] a);
    if (ld && f3 == 3'd7) return 0;
    if (!ld && f3 > 3'd3) return 0;
    return (a % 64'(size_of(f3))) == 64'd0;
  endfunction

  function automatic logic [63:0] load_value(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] rdata);
    logic [63:0] lane, mask, v;
    int nb;
    nb   = size_of(f3);
    lane = rdata >> (8 * a[2:0]);
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v    = lane & mask;
    if (f3 < 3'd4 && nb < 8 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] strobe_of(input logic [2:0] f3, input logic [63:0] a);
    logic [7:0] s;
    int off, nb;
    s   = '0;
    off = int'(a[2:0]);
    nb  = size_of(f3);
    for (int i = 0; i < 8; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
    return s;
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic do_txn(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [63:0] data, input logic [63:0] addr,
                        input logic [63:0] rdata, input int delay);
    bit ld, st;
    ld = (opc == 7'h03);
    st = (opc == 7'h23);
    wait_ready();
    in_valid = 1'b1; in_op = {f3, opc}; in_rd = rd; in_data = data; in_addr = addr;
    step();
    in_valid = 1'b0;
    in_op = 10'($urandom); in_rd = 5'($urandom); in_data = {$urandom, $urandom}; in_addr = {$urandom, $urandom};
    if (!ld && !st) begin
      check("pt_wb_en", wb_en, rd != 0);
      if (rd != 0) begin exp_rd = rd; exp_data = data; end
      check("pt_wb_rd", wb_rd, exp_rd);
      check("pt_wb_data", wb_data, exp_data);
      check("pt_mem_req", mem_req, 0);
      check("pt_in_ready", in_ready, 1);
    end else if (!is_legal(ld, f3, addr)) begin
      check("mis_pulse", misalign, 1);
      check("mis_mem_req", mem_req, 0);
      check("mis_wb_en", wb_en, 0);
      check("mis_in_ready", in_ready, 1);
      step();
      check("mis_pulse_end", misalign, 0);
      check("mis_mem_req2", mem_req, 0);
    end else begin
      check("req_mem_req", mem_req, 1);
      check("req_in_ready", in_ready, 0);
      check("req_mem_addr", mem_addr, addr & ~64'h7);
      check("req_mem_we", mem_we, st);
      if (st) begin
        check("req_strb", mem_strb, strobe_of(f3, addr));
        check("req_wdata", mem_wdata, data << (8 * addr[2:0]));
      end
      repeat (delay) begin
        step();
        check("hold_mem_req", mem_req, 1);
        check("hold_mem_addr", mem_addr, addr & ~64'h7);
        if (st) check("hold_strb", mem_strb, strobe_of(f3, addr));
        check("hold_wb_en", wb_en, 0);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      step();
      mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
      check("done_mem_req", mem_req, 0);
      check("done_wb_en", wb_en, ld && rd != 0);
      if (ld && rd != 0) begin exp_rd = rd; exp_data = load_value(f3, addr, rdata); end
      check("done_wb_rd", wb_rd, exp_rd);
      check("done_wb_data", wb_data, exp_data);
      check("done_mem_err", mem_err, 0);
      step();
      check("done_wb_pulse", wb_en, 0);
    end
  endtask

  task automatic idle_ack();
    mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
    step();
    mem_ack = 1'b0;
    check("stray_ack_wb_en", wb_en, 0);
    check("stray_ack_req", mem_req, 0);
    check("stray_ack_data", wb_data, exp_data);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] data, addr, rdata;
    int          kind;

    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_data = '0; in_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_rd = '0; exp_data = '0;
    step(); step();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_strb", mem_strb, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_misalign", misalign, 0);
    check("rst_mem_err", mem_err, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // directed cases
    do_txn(7'h33, 3'd0, 5'd5, 64'h1234, 64'h0, 64'h0, 0);
    check("dir_pt_data", wb_data, 64'h1234);
    do_txn(7'h33, 3'd0, 5'd0, 64'h5678, 64'h0, 64'h0, 0);
    check("dir_pt_rd0_keep", wb_data, 64'h1234);
    do_txn(7'h03, 3'd0, 5'd7, 64'h0, 64'h1003, 64'h0000_0000_8000_0000, TO - 1);
    check("dir_lb", exp_data, 64'hFFFF_FFFF_FFFF_FF80);
    do_txn(7'h03, 3'd4, 5'd8, 64'h0, 64'h1003, 64'h0000_0000_8000_0000, 2);
    check("dir_lbu", wb_data, 64'h80);
    do_txn(7'h23, 3'd1, 5'd3, 64'hBEEF, 64'h2006, 64'h0, 1);
    check("dir_sh_keep", wb_data, 64'h80);
    do_txn(7'h03, 3'd2, 5'd4, 64'h0, 64'h3002, 64'h0, 0);
    do_txn(7'h03, 3'd7, 5'd4, 64'h0, 64'h3000, 64'h0, 0);
    do_txn(7'h23, 3'd5, 5'd4, 64'h0, 64'h3000, 64'h0, 0);
    idle_ack();

    for (int i = 0; i < 150; i++) begin
      kind  = $urandom_range(0, 2);
      f3    = 3'($urandom_range(0, 7));
      rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      data  = {$urandom, $urandom};
      addr  = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      if (kind == 0) begin
        do opc = 7'($urandom_range(0, 127)); while (opc == 7'h03 || opc == 7'h23);
      end else begin
        opc = (kind == 1) ? 7'h03 : 7'h23;
        if ($urandom_range(0, 3) != 0) addr = addr & ~64'(size_of(f3) - 1);
      end
      do_txn(opc, f3, rd, data, addr, rdata, $urandom_range(0, TO - 1));
      if ($urandom_range(0, 3) == 0) idle_ack();
    end

    // reset in the second REQ cycle abandons the load
    wait_ready();
    in_valid = 1'b1; in_op = {3'd3, 7'h03}; in_rd = 5'd9; in_addr = 64'h4000; in_data = '0;
    step();
    in_valid = 1'b0;
    check("rr_req1", mem_req, 1);
    step();
    check("rr_req2", mem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_rd = '0; exp_data = '0;
    check("rr_req_dropped", mem_req, 0);
    check("rr_wb_data_clr", wb_data, 0);
    mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    step();
    mem_ack = 1'b0;
    check("rr_late_ack_wb", wb_en, 0);
    check("rr_late_ack_data", wb_data, 0);
    check("rr_late_ack_req", mem_req, 0);

`ifdef MEM_TIMEOUT_EN
    wait_ready();
    in_valid = 1'b1; in_op = {3'd3, 7'h03}; in_rd = 5'd10; in_addr = 64'h5000;
    step();
    in_valid = 1'b0;
    check("to_req_1", mem_req, 1);
    for (int c = 2; c <= TO; c++) begin
      step();
      check("to_req_n", mem_req, 1);
      check("to_err_early", mem_err, 0);
    end
    step();
    check("to_req_drop", mem_req, 0);
    check("to_err_pulse", mem_err, 1);
    check("to_wb_en", wb_en, 0);
    step();
    check("to_err_end", mem_err, 0);
    idle_ack();
`else
    check("no_to_mem_err", mem_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 256, giving the max cycles a request waits for mem_ack (used only with MEM_TIMEOUT_EN).
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
 clk  in  1  single clock; all state updates on posedge
 reset  in  1  synchronous, active-high reset
 in_valid  in  1  execute result valid
 in_ready  out  1  stage can accept
 in_op  in  10  {funct3, opcode[6:0]} of the instruction
 in_rd  in  5  destination register
 in_data  in  64  execute result, or store data for stores
 in_addr  in  64  effective address for loads/stores
 mem_req  out  1  data-memory request
 mem_we  out  1  1 = store, 0 = load
 mem_addr  out  64  doubleword-aligned address
 mem_wdata  out  64  lane-shifted store data
 mem_strb  out  8  byte strobes
 mem_ack  in  1  memory completes request this cycle
 mem_rdata  in  64  doubleword read data, valid with mem_ack
 wb_en  out  1  register-file write enable
 wb_rd  out  5  write-back register
 wb_data  out  64  write-back value
 misalign  out  1  one-cycle pulse: misaligned or illegal access dropped
 mem_err  out  1  one-cycle pulse: request timed out

Function
REQ-003 Accept SHALL occur on a cycle with in_valid && in_ready; in_ready = (state == IDLE) && !reset.
REQ-004 Class: in_op[6:0]=0x03 load, 0x23 store, any other value pass-through.
REQ-005 Pass-through: cycle after accept, wb_en=(in_rd!=0), wb_rd=in_rd, wb_data=in_data; state stays IDLE (throughput 1/cycle).
REQ-006 States SHALL be IDLE and REQ; an aligned legal load/store moves IDLE->REQ on accept.
REQ-007 In REQ: mem_req=1, mem_addr={in_addr[63:3],3'b000}, mem_we, mem_wdata, mem_strb held stable until the handshake.
REQ-008 Handshake completes on the first cycle with mem_req && mem_ack (ack in the first REQ cycle allowed); state -> IDLE on that edge.
REQ-009 Load completion: lane = rdata >> (addr[2:0]*8); funct3 0/1/2/3 sign-extend 8/16/32/64 bits, 4/5/6 zero-extend 8/16/32; wb_en=(rd!=0) the cycle after ack.
REQ-010 Store: strb = 0x01/0x03/0x0F/0xFF << addr[2:0] for funct3 0/1/2/3; wdata = in_data << (addr[2:0]*8); no write-back.
REQ-011 Misaligned (h: addr[0]!=0; w/wu: addr[1:0]!=0; d: addr[2:0]!=0), load funct3=7, or store funct3>3: no request, no wb, misalign=1 the cycle after accept, state stays IDLE.
REQ-012 mem_ack while mem_req=0 SHALL be ignored.
REQ-013 wb_en, misalign, mem_err SHALL be single-cycle pulses; wb_rd/wb_data hold last value otherwise.

Reset
REQ-014 On reset: state IDLE; mem_req, mem_we, mem_strb, wb_en, misalign, mem_err, in_ready = 0; mem_addr, mem_wdata, wb_rd, wb_data = 0.
REQ-015 Reset during REQ SHALL abandon the transaction: mem_req 0 after that edge, no wb, later mem_ack ignored.

Configuration
REQ-016 With MEM_TIMEOUT_EN defined: a counter clears on entering REQ, increments each REQ cycle without ack; on reaching TIMEOUT_CYCLES, mem_req drops, mem_err pulses 1 cycle, no wb, state -> IDLE; ack on that same cycle wins.
REQ-017 Without MEM_TIMEOUT_EN: REQ waits indefinitely; mem_err tied 0; no counter logic.

Verification
REQ-018 Pass-through op=0x033 rd=5 data=0x1234 -> wb_en=1, wb_rd=5, wb_data=0x1234 next cycle; rd=0 -> wb_en=0.
REQ-019 lb (0x003) addr=0x1003, rdata=0x0000_0000_8000_0000, ack after 3 cycles -> mem_addr=0x1000, wb_data=0xFFFF_FFFF_FFFF_FF80; lbu (0x203) same -> 0x80.
REQ-020 sh (0x0A3) addr=0x2006 data=0xBEEF -> mem_we=1, mem_strb=0xC0, mem_wdata=0xBEEF_0000_0000_0000, no wb_en.
REQ-021 lw (0x103) addr=0x3002 -> misalign pulse, mem_req never asserts, in_ready stays 1.
REQ-022 ld with no ack: MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 -> mem_err after 4 REQ cycles; reset asserted in 2nd REQ cycle -> mem_req=0 next cycle, later ack yields no wb.
